// File: rtl/mon_pkg.sv
// Shared types and default constants for the CPU data-port store monitor.
package mon_pkg;

    typedef enum logic [1:0] {
        StRun,
        StPass,
        StFail,
        StTimeout
    } mon_state_e;

    localparam logic [31:0] DefPassAddr  = 32'd84;
    localparam logic [31:0] DefPassData  = 32'd7;
    localparam logic [31:0] DefAllowAddr = 32'd80;

endpackage

// File: rtl/mem_store_monitor_if.sv
// CPU data-port store bus as seen by the monitor: one store per cycle with memwrite high.
interface mem_store_monitor_if;

    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    modport master (
        output memwrite,
        output dataadr,
        output writedata
    );

    modport slave (
        input memwrite,
        input dataadr,
        input writedata
    );

endinterface

// File: rtl/mem_store_monitor.sv
// Watches CPU stores and decides PASS/FAIL from the address/data written.
// Optional cycle-budget timeout enabled by defining MEM_STORE_MONITOR_TIMEOUT_EN.
module mem_store_monitor
    import mon_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DefPassAddr,
    parameter logic [31:0] PASS_DATA      = DefPassData,
    parameter logic [31:0] ALLOW_ADDR     = DefAllowAddr,
    parameter int unsigned TIMEOUT_CYCLES = 32'd100000
) (
    input  logic                clk,
    input  logic                rst,
    mem_store_monitor_if.slave  store_if,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [15:0]         store_count,
    output logic [31:0]         cycle_count,
    output logic [31:0]         fail_addr,
    output logic [31:0]         fail_data
);

    mon_state_e  state_q, state_d;
    logic [15:0] store_count_q, store_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] fail_addr_q, fail_addr_d;
    logic [31:0] fail_data_q, fail_data_d;
    logic        done_q, pass_q, fail_q;

`ifdef MEM_STORE_MONITOR_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = TIMEOUT_CYCLES - 32'd1;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        store_count_d = store_count_q;
        cycle_count_d = cycle_count_q;
        fail_addr_d   = fail_addr_q;
        fail_data_d   = fail_data_q;

        if (state_q == StRun) begin
            if (cycle_count_q != 32'hFFFF_FFFF) begin
                cycle_count_d = cycle_count_q + 32'd1;
            end

            if (store_if.memwrite) begin
                if (store_count_q != 16'hFFFF) begin
                    store_count_d = store_count_q + 16'd1;
                end
                // PASS_ADDR is tested first so it wins when it equals ALLOW_ADDR.
                if (store_if.dataadr == PASS_ADDR) begin
                    if (store_if.writedata == PASS_DATA) begin
                        state_d = StPass;
                    end else begin
                        state_d     = StFail;
                        fail_addr_d = store_if.dataadr;
                        fail_data_d = store_if.writedata;
                    end
                end else if (store_if.dataadr != ALLOW_ADDR) begin
                    state_d     = StFail;
                    fail_addr_d = store_if.dataadr;
                    fail_data_d = store_if.writedata;
                end
            end

`ifdef MEM_STORE_MONITOR_TIMEOUT_EN
            // A deciding store in the final budget cycle takes precedence.
            if (state_d == StRun && cycle_count_q == TimeoutLast) begin
                state_d     = StTimeout;
                fail_addr_d = 32'hFFFF_FFFF;
                fail_data_d = 32'hFFFF_FFFF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StRun;
            store_count_q <= 16'd0;
            cycle_count_q <= 32'd0;
            fail_addr_q   <= 32'd0;
            fail_data_q   <= 32'd0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            store_count_q <= store_count_d;
            cycle_count_q <= cycle_count_d;
            fail_addr_q   <= fail_addr_d;
            fail_data_q   <= fail_data_d;
            done_q        <= (state_d != StRun);
            pass_q        <= (state_d == StPass);
            fail_q        <= (state_d == StFail) || (state_d == StTimeout);
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign store_count = store_count_q;
    assign cycle_count = cycle_count_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mem_store_monitor.sv
// Self-checking bench for mem_store_monitor: directed scenarios plus randomized store streams.
module tb_mem_store_monitor;

    localparam int unsigned TimeoutCycles = 50;
    localparam int          RLen          = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done, pass, fail;
    logic [15:0] store_count;
    logic [31:0] cycle_count, fail_addr, fail_data;
    int          checks   = 0;
    int          failures = 0;

    mem_store_monitor_if sbus ();

    mem_store_monitor #(
        .PASS_ADDR      (32'd84),
        .PASS_DATA      (32'd7),
        .ALLOW_ADDR     (32'd80),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .store_if    (sbus),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .store_count (store_count),
        .cycle_count (cycle_count),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        sbus.memwrite = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        sbus.memwrite  = 1'b1;
        sbus.dataadr   = a;
        sbus.writedata = d;
        tick();
        sbus.memwrite  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks += 7;
        if (done !== 1'b0) begin failures++; $display("FAIL %s done: got %b want 0", tag, done); end
        if (pass !== 1'b0) begin failures++; $display("FAIL %s pass: got %b want 0", tag, pass); end
        if (fail !== 1'b0) begin failures++; $display("FAIL %s fail: got %b want 0", tag, fail); end
        if (store_count !== 16'd0) begin
            failures++; $display("FAIL %s store_count: got %0d want 0", tag, store_count);
        end
        if (cycle_count !== 32'd0) begin
            failures++; $display("FAIL %s cycle_count: got %0d want 0", tag, cycle_count);
        end
        if (fail_addr !== 32'd0) begin
            failures++; $display("FAIL %s fail_addr: got %0h want 0", tag, fail_addr);
        end
        if (fail_data !== 32'd0) begin
            failures++; $display("FAIL %s fail_data: got %0h want 0", tag, fail_data);
        end
    endtask

    task automatic test_reset();
        sbus.dataadr = 32'd88;
        sbus.writedata = 32'd1;
        do_reset(10);
        check_reset_values("reset");
        // Reset mid-test with a failing store on the bus must be ignored.
        store(32'd80, 32'd1);
        rst = 1'b0;
        sbus.memwrite = 1'b1;
        sbus.dataadr = 32'd88;
        tick();
        rst = 1'b1;
        sbus.memwrite = 1'b0;
        check_reset_values("reset_mid");
    endtask

    task automatic test_pass();
        do_reset(10);
        store(32'd80, 32'd5);
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("FAIL pass_allow done: got %b want 0", done); end
        if (store_count !== 16'd1) begin
            failures++; $display("FAIL pass_allow store_count: got %0d want 1", store_count);
        end
        store(32'd84, 32'd7);
        checks += 5;
        if (done !== 1'b1) begin failures++; $display("FAIL pass done: got %b want 1", done); end
        if (pass !== 1'b1) begin failures++; $display("FAIL pass pass: got %b want 1", pass); end
        if (fail !== 1'b0) begin failures++; $display("FAIL pass fail: got %b want 0", fail); end
        if (store_count !== 16'd2) begin
            failures++; $display("FAIL pass store_count: got %0d want 2", store_count);
        end
        if (cycle_count !== 32'd2) begin
            failures++; $display("FAIL pass cycle_count: got %0d want 2", cycle_count);
        end
    endtask

    task automatic test_reset_after_pass();
        do_reset(1);
        check_reset_values("rst_after_pass");
        store(32'd84, 32'd7);
        checks += 2;
        if (pass !== 1'b1) begin failures++; $display("FAIL repass pass: got %b want 1", pass); end
        if (store_count !== 16'd1) begin
            failures++; $display("FAIL repass store_count: got %0d want 1", store_count);
        end
    endtask

    task automatic test_fail_data();
        do_reset(2);
        store(32'd84, 32'd6);
        checks += 5;
        if (fail !== 1'b1) begin failures++; $display("FAIL bad_data fail: got %b want 1", fail); end
        if (pass !== 1'b0) begin failures++; $display("FAIL bad_data pass: got %b want 0", pass); end
        if (done !== 1'b1) begin failures++; $display("FAIL bad_data done: got %b want 1", done); end
        if (fail_addr !== 32'd84) begin
            failures++; $display("FAIL bad_data fail_addr: got %0d want 84", fail_addr);
        end
        if (fail_data !== 32'd6) begin
            failures++; $display("FAIL bad_data fail_data: got %0d want 6", fail_data);
        end
    endtask

    task automatic test_fail_addr();
        do_reset(2);
        store(32'd88, 32'd7);
        store(32'd84, 32'd7);
        repeat (3) tick();
        checks += 6;
        if (fail !== 1'b1) begin failures++; $display("FAIL bad_addr fail: got %b want 1", fail); end
        if (pass !== 1'b0) begin failures++; $display("FAIL bad_addr pass: got %b want 0", pass); end
        if (fail_addr !== 32'd88) begin
            failures++; $display("FAIL bad_addr fail_addr: got %0d want 88", fail_addr);
        end
        if (fail_data !== 32'd7) begin
            failures++; $display("FAIL bad_addr fail_data: got %0d want 7", fail_data);
        end
        if (store_count !== 16'd1) begin
            failures++; $display("FAIL bad_addr store_count: got %0d want 1", store_count);
        end
        if (cycle_count !== 32'd1) begin
            failures++; $display("FAIL bad_addr cycle_count: got %0d want 1", cycle_count);
        end
    endtask

    task automatic test_idle();
        do_reset(2);
        sbus.memwrite = 1'b0;
        sbus.dataadr = 32'd84;
        sbus.writedata = 32'd7;
        repeat (20) tick();
        checks += 3;
        if (done !== 1'b0) begin failures++; $display("FAIL idle done: got %b want 0", done); end
        if (store_count !== 16'd0) begin
            failures++; $display("FAIL idle store_count: got %0d want 0", store_count);
        end
        if (cycle_count !== 32'd20) begin
            failures++; $display("FAIL idle cycle_count: got %0d want 20", cycle_count);
        end
    endtask

    task automatic test_timeout();
        do_reset(2);
`ifdef MEM_STORE_MONITOR_TIMEOUT_EN
        repeat (TimeoutCycles - 1) tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL to_early done: got %b want 0", done); end
        repeat (4) tick();
        checks += 6;
        if (done !== 1'b1) begin failures++; $display("FAIL to done: got %b want 1", done); end
        if (fail !== 1'b1) begin failures++; $display("FAIL to fail: got %b want 1", fail); end
        if (pass !== 1'b0) begin failures++; $display("FAIL to pass: got %b want 0", pass); end
        if (cycle_count !== 32'd50) begin
            failures++; $display("FAIL to cycle_count: got %0d want 50", cycle_count);
        end
        if (fail_addr !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL to fail_addr: got %0h want ffffffff", fail_addr);
        end
        if (fail_data !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL to fail_data: got %0h want ffffffff", fail_data);
        end
        // A deciding store in the last budget cycle beats the timeout.
        do_reset(1);
        repeat (TimeoutCycles - 1) tick();
        store(32'd84, 32'd7);
        checks += 3;
        if (pass !== 1'b1) begin failures++; $display("FAIL to_race pass: got %b want 1", pass); end
        if (fail !== 1'b0) begin failures++; $display("FAIL to_race fail: got %b want 0", fail); end
        if (cycle_count !== 32'd50) begin
            failures++; $display("FAIL to_race cycle_count: got %0d want 50", cycle_count);
        end
`else
        repeat (TimeoutCycles + 10) tick();
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("FAIL no_to done: got %b want 0", done); end
        if (cycle_count !== 32'd60) begin
            failures++; $display("FAIL no_to cycle_count: got %0d want 60", cycle_count);
        end
`endif
    endtask

    task automatic test_random();
        logic        mw  [RLen];
        logic [31:0] adr [RLen];
        logic [31:0] dat [RLen];
        logic        e_done, e_pass, e_fail;
        int          e_sc, e_cc, dk, r;
        logic [31:0] e_fa, e_fd;

        for (int trial = 0; trial < 30; trial++) begin
            for (int k = 0; k < RLen; k++) begin
                mw[k] = (k < RLen - 5) ? 1'($urandom_range(0, 1)) : 1'b0;
                r = $urandom_range(0, 99);
                adr[k] = (r < 93) ? 32'd80 : (r < 97) ? 32'd84 : ($urandom & 32'hFFFF_FFFC);
                dat[k] = (adr[k] == 32'd84 && $urandom_range(0, 1) == 1) ? 32'd7 : $urandom;
            end

            // Reference: scan the stream; first non-allowed outcome decides.
            e_done = 1'b0; e_pass = 1'b0; e_fail = 1'b0;
            e_sc = 0; e_cc = 0; e_fa = 32'd0; e_fd = 32'd0; dk = RLen + 1;
            for (int k = 0; k < RLen; k++) begin
                if (!e_done) begin
                    e_cc++;
                    if (mw[k]) begin
                        e_sc++;
                        if (adr[k] == 32'd84) begin
                            e_done = 1'b1;
                            if (dat[k] == 32'd7) e_pass = 1'b1;
                            else begin e_fail = 1'b1; e_fa = adr[k]; e_fd = dat[k]; end
                        end else if (adr[k] != 32'd80) begin
                            e_done = 1'b1; e_fail = 1'b1; e_fa = adr[k]; e_fd = dat[k];
                        end
                    end
`ifdef MEM_STORE_MONITOR_TIMEOUT_EN
                    if (!e_done && k == int'(TimeoutCycles) - 1) begin
                        e_done = 1'b1; e_fail = 1'b1; e_fa = 32'hFFFF_FFFF; e_fd = 32'hFFFF_FFFF;
                    end
`endif
                    if (e_done) dk = k;
                end
            end

            do_reset(2);
            for (int k = 0; k < RLen; k++) begin
                sbus.memwrite  = mw[k];
                sbus.dataadr   = adr[k];
                sbus.writedata = dat[k];
                tick();
                checks++;
                if (done !== (k >= dk)) begin
                    failures++;
                    $display("FAIL rnd%0d done@%0d: got %b want %b", trial, k, done, (k >= dk));
                end
            end
            sbus.memwrite = 1'b0;

            checks += 6;
            if (pass !== e_pass) begin
                failures++; $display("FAIL rnd%0d pass: got %b want %b", trial, pass, e_pass);
            end
            if (fail !== e_fail) begin
                failures++; $display("FAIL rnd%0d fail: got %b want %b", trial, fail, e_fail);
            end
            if (store_count !== 16'(e_sc)) begin
                failures++;
                $display("FAIL rnd%0d store_count: got %0d want %0d", trial, store_count, e_sc);
            end
            if (cycle_count !== 32'(e_cc)) begin
                failures++;
                $display("FAIL rnd%0d cycle_count: got %0d want %0d", trial, cycle_count, e_cc);
            end
            if (fail_addr !== e_fa) begin
                failures++;
                $display("FAIL rnd%0d fail_addr: got %0h want %0h", trial, fail_addr, e_fa);
            end
            if (fail_data !== e_fd) begin
                failures++;
                $display("FAIL rnd%0d fail_data: got %0h want %0h", trial, fail_data, e_fd);
            end
        end
    endtask

    initial begin
        sbus.memwrite  = 1'b0;
        sbus.dataadr   = 32'd0;
        sbus.writedata = 32'd0;
        test_reset();
        test_pass();
        test_reset_after_pass();
        test_fail_data();
        test_fail_addr();
        test_idle();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
